pc_seq_unit: RTL and testbench

PC_SEQ_UNIT -- requirements
Module: pc_seq_unit

---
 rtl/pc_seq_unit.sv | 135 +++++++++++++
 tb/tb_pc_seq_unit.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/pc_seq_unit.sv
// ---------------------------------------------------------------------------
// pc_seq_unit
//   Program-counter sequencer with a circular return-address stack (RAS).
//   Each rising clk edge picks one action by fixed priority:
//     stall > ret_en > call_en > branch_en > sequential (pc + 1).
//   A call pushes pc_plus1 and jumps to target. A return pops the top entry
//   and jumps to it. A call on a full stack overwrites the oldest entry.
//   A return on an empty stack falls through to pc_plus1. Both of these
//   cases set the sticky ras_err flag.
//
// Ports
//   clk        in   single clock, rising edge
//   reset      in   asynchronous, active-low reset
//   stall      in   hold all state this cycle
//   branch_en  in   load target
//   call_en    in   push pc_plus1, load target
//   ret_en     in   pop stack, load popped address
//   target     in   [AW-1:0] branch/call destination
//   pc_out     out  [AW-1:0] registered current PC
//   pc_plus1   out  [AW-1:0] combinational pc_out + 1 (wraps)
//   ras_count  out  number of valid stack entries (registered)
//   ras_err    out  sticky overflow/underflow flag (registered)
// ---------------------------------------------------------------------------
module pc_seq_unit #(
    parameter int              AW         = 4,
    parameter int              RAS_DEPTH  = 4,
    parameter logic [AW-1:0]   RESET_ADDR = '0
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               stall,
    input  logic                               branch_en,
    input  logic                               call_en,
    input  logic                               ret_en,
    input  logic [AW-1:0]                      target,
    output logic [AW-1:0]                      pc_out,
    output logic [AW-1:0]                      pc_plus1,
    output logic [$clog2(RAS_DEPTH+1)-1:0]     ras_count,
    output logic                               ras_err
);

    localparam int CW = $clog2(RAS_DEPTH + 1);
    localparam int PW = $clog2(RAS_DEPTH);

    localparam logic [CW-1:0] DEPTH_C = CW'(RAS_DEPTH);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = '0;
    localparam logic [PW-1:0] TOP_MAX = PW'(RAS_DEPTH - 1);
    localparam logic [PW-1:0] TOP_ONE = PW'(1);
    localparam logic [AW-1:0] PC_ONE = AW'(1);

    // State
    logic [AW-1:0] r_pc;
    logic [CW-1:0] r_count;
    logic [PW-1:0] r_top;      // index of the next free slot (one past top)
    logic          r_err;
    logic [AW-1:0] r_stack [RAS_DEPTH];

    // Next-state wires
    logic [AW-1:0] w_pc_plus1;
    logic [AW-1:0] w_pc_next;
    logic [CW-1:0] w_count_next;
    logic [PW-1:0] w_top_next;
    logic          w_err_next;
    logic          w_push;
    logic [PW-1:0] w_top_inc;
    logic [PW-1:0] w_top_dec;

    assign w_pc_plus1 = r_pc + PC_ONE;

    // Pointer arithmetic wraps explicitly so non-power-of-two depths work.
    assign w_top_inc = (r_top == TOP_MAX) ? '0 : r_top + TOP_ONE;
    assign w_top_dec = (r_top == '0) ? TOP_MAX : r_top - TOP_ONE;

    always_comb begin
        w_pc_next    = r_pc;
        w_count_next = r_count;
        w_top_next   = r_top;
        w_err_next   = r_err;
        w_push       = 1'b0;
        if (stall) begin
            // hold everything
        end else if (ret_en) begin
            if (r_count != CNT_ZERO) begin
                w_pc_next    = r_stack[w_top_dec];
                w_top_next   = w_top_dec;
                w_count_next = r_count - CNT_ONE;
            end else begin
                w_pc_next  = w_pc_plus1;
                w_err_next = 1'b1;
            end
        end else if (call_en) begin
            w_push     = 1'b1;
            w_pc_next  = target;
            w_top_next = w_top_inc;
            // When full, the write slot is the oldest entry; the count saturates.
            if (r_count == DEPTH_C) begin
                w_err_next = 1'b1;
            end else begin
                w_count_next = r_count + CNT_ONE;
            end
        end else if (branch_en) begin
            w_pc_next = target;
        end else begin
            w_pc_next = w_pc_plus1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc    <= RESET_ADDR;
            r_count <= '0;
            r_top   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_pc    <= w_pc_next;
            r_count <= w_count_next;
            r_top   <= w_top_next;
            r_err   <= w_err_next;
        end
    end

    // Stack storage has no reset; entries are unreadable while the count is 0.
    always_ff @(posedge clk) begin
        if (w_push && reset) begin
            r_stack[r_top] <= w_pc_plus1;
        end
    end

    assign pc_out    = r_pc;
    assign pc_plus1  = w_pc_plus1;
    assign ras_count = r_count;
    assign ras_err   = r_err;

endmodule

// File: tb/tb_pc_seq_unit.sv
module tb_pc_seq_unit;

    logic       clk;
    logic       reset;
    logic       stall;
    logic       branch_en;
    logic       call_en;
    logic       ret_en;
    logic [3:0] target;
    logic [3:0] pc_out;
    logic [3:0] pc_plus1;
    logic [2:0] ras_count;
    logic       ras_err;

    pc_seq_unit #(.AW(4), .RAS_DEPTH(4), .RESET_ADDR(4'd0)) dut (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .branch_en (branch_en),
        .call_en   (call_en),
        .ret_en    (ret_en),
        .target    (target),
        .pc_out    (pc_out),
        .pc_plus1  (pc_plus1),
        .ras_count (ras_count),
        .ras_err   (ras_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int         due;
        logic [3:0] pc;
        logic [2:0] cnt;
        logic       err;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // Monitor: the DUT presents a new state after every edge; compare against
    // each expectation whose edge has already occurred.
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            exp_t e;
            logic [3:0] exp_p1;
            e = exp_q.pop_front();
            exp_p1 = e.pc + 4'd1;
            $display("txn %-14s pc=%0d cnt=%0d err=%0d (exp pc=%0d cnt=%0d err=%0d)",
                     e.name, pc_out, ras_count, ras_err, e.pc, e.cnt, e.err);
            check({e.name, ".pc"},    int'(pc_out),    int'(e.pc));
            check({e.name, ".cnt"},   int'(ras_count), int'(e.cnt));
            check({e.name, ".err"},   int'(ras_err),   int'(e.err));
            check({e.name, ".plus1"}, int'(pc_plus1),  int'(exp_p1));
        end
    end

    // Drive one cycle of controls, record the expected post-edge state, then
    // park the controls at stall so idle gaps leave the state untouched.
    task automatic drive(input string name, input logic st, input logic r,
                         input logic c, input logic b, input logic [3:0] t,
                         input logic [3:0] epc, input logic [2:0] ecnt,
                         input logic eerr);
        exp_t e;
        stall = st; ret_en = r; call_en = c; branch_en = b; target = t;
        e.due = cyc + 1; e.pc = epc; e.cnt = ecnt; e.err = eerr; e.name = name;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        stall = 1'b1; ret_en = 1'b0; call_en = 1'b0; branch_en = 1'b0;
    endtask

    task automatic drain();
        int budget = 20;
        while (exp_q.size() > 0 && budget > 0) begin
            @(negedge clk);
            #1;
            budget--;
        end
        if (exp_q.size() > 0) begin
            check("drain_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; stall = 1'b1; ret_en = 1'b0; call_en = 1'b0;
        branch_en = 1'b0; target = 4'd0;
        #2;
        check("rst.pc",  int'(pc_out),    0);
        check("rst.cnt", int'(ras_count), 0);
        check("rst.err", int'(ras_err),   0);
        @(negedge clk);
        reset = 1'b1;

        // Sequential wrap: 16 idle edges -> 1..15, 0
        for (int i = 1; i <= 16; i++)
            drive($sformatf("seq%0d", i), 0, 0, 0, 0, 4'd0, 4'(i % 16), 3'd0, 1'b0);

        // Call / return
        for (int i = 1; i <= 3; i++)
            drive("to3", 0, 0, 0, 0, 4'd0, 4'(i), 3'd0, 1'b0);
        drive("call9",   0, 0, 1, 0, 4'd9, 4'd9,  3'd1, 1'b0);
        drive("idle10",  0, 0, 0, 0, 4'd0, 4'd10, 3'd1, 1'b0);
        drive("idle11",  0, 0, 0, 0, 4'd0, 4'd11, 3'd1, 1'b0);
        drive("ret4",    0, 1, 0, 0, 4'd0, 4'd4,  3'd0, 1'b0);

        // Overflow: branch to 1, five nested calls (targets pc+1)
        drive("br1",     0, 0, 0, 1, 4'd1, 4'd1, 3'd0, 1'b0);
        drive("call2",   0, 0, 1, 0, 4'd2, 4'd2, 3'd1, 1'b0);
        drive("call3",   0, 0, 1, 0, 4'd3, 4'd3, 3'd2, 1'b0);
        drive("call4",   0, 0, 1, 0, 4'd4, 4'd4, 3'd3, 1'b0);
        drive("call5",   0, 0, 1, 0, 4'd5, 4'd5, 3'd4, 1'b0);
        drive("call6ovf",0, 0, 1, 0, 4'd6, 4'd6, 3'd4, 1'b1);
        drive("ret6",    0, 1, 0, 0, 4'd0, 4'd6, 3'd3, 1'b1);
        drive("ret5",    0, 1, 0, 0, 4'd0, 4'd5, 3'd2, 1'b1);
        drive("ret4b",   0, 1, 0, 0, 4'd0, 4'd4, 3'd1, 1'b1);
        drive("ret3",    0, 1, 0, 0, 4'd0, 4'd3, 3'd0, 1'b1);
        drive("ret_unf", 0, 1, 0, 0, 4'd0, 4'd4, 3'd0, 1'b1);

        // Priority
        drive("call8",   0, 0, 1, 0, 4'd8,  4'd8,  3'd1, 1'b1);
        drive("stall_all",1, 1, 1, 1, 4'd12, 4'd8, 3'd1, 1'b1);
        drive("ret_all", 0, 1, 1, 1, 4'd12, 4'd5,  3'd0, 1'b1);
        drive("nopush",  0, 0, 0, 0, 4'd0,  4'd6,  3'd0, 1'b1);
        drive("call_br", 0, 0, 1, 1, 4'd10, 4'd10, 3'd1, 1'b1);
        drive("br2",     0, 0, 0, 1, 4'd2,  4'd2,  3'd1, 1'b1);
        drive("ret7",    0, 1, 0, 0, 4'd0,  4'd7,  3'd0, 1'b1);
        drain();

        // Underflow after a fresh reset
        reset = 1'b0;
        #1;
        check("rst2.err", int'(ras_err), 0);
        @(negedge clk);
        reset = 1'b1;
        drive("unf",     0, 1, 0, 0, 4'd0, 4'd1, 3'd0, 1'b1);
        drive("unf_c5",  0, 0, 1, 0, 4'd5, 4'd5, 3'd1, 1'b1);
        drive("unf_i6",  0, 0, 0, 0, 4'd0, 4'd6, 3'd1, 1'b1);
        drive("c9",      0, 0, 1, 0, 4'd9, 4'd9, 3'd2, 1'b1);
        drain();

        // Asynchronous reset between edges with two entries on the stack
        #3;
        reset = 1'b0;
        #1;
        check("arst.pc",  int'(pc_out),    0);
        check("arst.cnt", int'(ras_count), 0);
        check("arst.err", int'(ras_err),   0);
        call_en = 1'b1; stall = 1'b0; target = 4'd7;
        @(posedge clk);
        #1;
        check("arst_hold.pc",  int'(pc_out),    0);
        check("arst_hold.cnt", int'(ras_count), 0);
        @(negedge clk);
        stall = 1'b1; call_en = 1'b0;
        reset = 1'b1;
        drive("post_idle", 0, 0, 0, 0, 4'd0, 4'd1, 3'd0, 1'b0);
        drive("post_ret",  0, 1, 0, 0, 4'd0, 4'd2, 3'd0, 1'b1);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
